// File: rtl/rc_unit_vc.sv
// Per-input-port route computation (XY/YX, mesh or torus) with a route held per VC from head to tail.
// Route is valid one cycle after the head edge; no backpressure, one head and one tail accepted every cycle.
module rc_unit_vc #(
    parameter int MESH_SIZE_X  = 4,
    parameter int MESH_SIZE_Y  = 4,
    parameter int X_CURRENT    = MESH_SIZE_X / 2,
    parameter int Y_CURRENT    = MESH_SIZE_Y / 2,
    parameter int VC_NUM       = 2,
    parameter int ROUTING_MODE = 0,
    parameter int TORUS        = 0,
    localparam int XW = (MESH_SIZE_X > 1) ? $clog2(MESH_SIZE_X) : 1,
    localparam int YW = (MESH_SIZE_Y > 1) ? $clog2(MESH_SIZE_Y) : 1,
    localparam int VW = (VC_NUM > 1) ? $clog2(VC_NUM) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  head_valid_i,
    input  logic [VW-1:0]         head_vc_i,
    input  logic [XW-1:0]         x_dest_i,
    input  logic [YW-1:0]         y_dest_i,
    input  logic                  tail_valid_i,
    input  logic [VW-1:0]         tail_vc_i,
    output logic [VC_NUM-1:0]     route_valid_o,
    output logic [VC_NUM*3-1:0]   out_port_o,
    output logic                  error_o
);

    localparam logic [2:0] P_CENTER = 3'd0;
    localparam logic [2:0] P_LEFT   = 3'd1;
    localparam logic [2:0] P_RIGHT  = 3'd2;
    localparam logic [2:0] P_UP     = 3'd3;
    localparam logic [2:0] P_DOWN   = 3'd4;

    localparam int XHALF = MESH_SIZE_X / 2;
    localparam int YHALF = MESH_SIZE_Y / 2;
    localparam logic [XW:0] XN = MESH_SIZE_X[XW:0];
    localparam logic [YW:0] YN = MESH_SIZE_Y[YW:0];
    localparam logic [XW:0] XC = X_CURRENT[XW:0];
    localparam logic [YW:0] YC = Y_CURRENT[YW:0];
    localparam logic [XW:0] XH = XHALF[XW:0];
    localparam logic [YW:0] YH = YHALF[YW:0];

    typedef enum logic [1:0] {
        S_IDLE,
        S_ROUTED,
        S_LAST
    } state_t;

    state_t      state_q [VC_NUM];
    state_t      state_d [VC_NUM];
    logic [2:0]  port_q  [VC_NUM];
    logic [2:0]  port_d  [VC_NUM];
    logic        error_q;
    logic        error_d;

    logic [XW:0]       x_ext;
    logic [XW:0]       dx;
    logic [YW:0]       y_ext;
    logic [YW:0]       dy;
    logic [2:0]        dir_x;
    logic [2:0]        dir_y;
    logic [2:0]        new_port;
    logic              dest_ok;
    logic [VC_NUM-1:0] head_hit;
    logic [VC_NUM-1:0] tail_hit;

    // Torus offsets are (dest - cur) mod N; adding N once replaces the divider since |dest - cur| < N.
    always_comb begin
        x_ext = {1'b0, x_dest_i};
        y_ext = {1'b0, y_dest_i};
        dx    = (x_ext >= XC) ? (x_ext - XC) : (x_ext + XN - XC);
        dy    = (y_ext >= YC) ? (y_ext - YC) : (y_ext + YN - YC);
        dir_x = P_CENTER;
        dir_y = P_CENTER;
        if (TORUS != 0) begin
            if (dx != '0) dir_x = (dx <= XH) ? P_RIGHT : P_LEFT;
            if (dy != '0) dir_y = (dy <= YH) ? P_DOWN : P_UP;
        end else begin
            if (x_ext < XC)      dir_x = P_LEFT;
            else if (x_ext > XC) dir_x = P_RIGHT;
            if (y_ext < YC)      dir_y = P_UP;
            else if (y_ext > YC) dir_y = P_DOWN;
        end
        if (ROUTING_MODE == 0) new_port = (dir_x != P_CENTER) ? dir_x : dir_y;
        else                   new_port = (dir_y != P_CENTER) ? dir_y : dir_x;
        dest_ok = (x_ext < XN) && (y_ext < YN);
    end

    always_comb begin
        head_hit = '0;
        tail_hit = '0;
        for (int v = 0; v < VC_NUM; v++) begin
            head_hit[v] = head_valid_i && (head_vc_i == VW'(v));
            tail_hit[v] = tail_valid_i && (tail_vc_i == VW'(v));
        end
    end

    always_comb begin
        error_d = 1'b0;
        for (int v = 0; v < VC_NUM; v++) begin
            state_d[v] = state_q[v];
            port_d[v]  = port_q[v];
            case (state_q[v])
                S_IDLE, S_LAST: begin
                    // A single-flit route lives one cycle; a tail with no packet in flight is an error.
                    state_d[v] = S_IDLE;
                    if (head_hit[v]) begin
                        if (dest_ok) begin
                            state_d[v] = tail_hit[v] ? S_LAST : S_ROUTED;
                            port_d[v]  = new_port;
                        end else begin
                            error_d = 1'b1;
                        end
                    end else if (tail_hit[v]) begin
                        error_d = 1'b1;
                    end
                end
                S_ROUTED: begin
                    if (tail_hit[v]) begin
                        state_d[v] = S_IDLE;
                        if (head_hit[v]) begin
                            if (dest_ok) begin
                                state_d[v] = S_ROUTED;
                                port_d[v]  = new_port;
                            end else begin
                                error_d = 1'b1;
                            end
                        end
                    end else if (head_hit[v]) begin
                        error_d = 1'b1;
                    end
                end
                default: state_d[v] = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int v = 0; v < VC_NUM; v++) begin
                state_q[v] <= S_IDLE;
                port_q[v]  <= P_CENTER;
            end
            error_q <= 1'b0;
        end else begin
            for (int v = 0; v < VC_NUM; v++) begin
                state_q[v] <= state_d[v];
                port_q[v]  <= port_d[v];
            end
            error_q <= error_d;
        end
    end

    always_comb begin
        route_valid_o = '0;
        out_port_o    = '0;
        for (int v = 0; v < VC_NUM; v++) begin
            route_valid_o[v]     = (state_q[v] != S_IDLE);
            out_port_o[v*3 +: 3] = port_q[v];
        end
    end

    assign error_o = error_q;

endmodule

// File: tb/tb_rc_unit_vc.sv
// Five configurations share one stimulus stream; a route model derived from the direction rules is checked every cycle.
module tb_rc_unit_vc;

    localparam int CENTER = 0;
    localparam int LEFT   = 1;
    localparam int RIGHT  = 2;
    localparam int UP     = 3;
    localparam int DOWN   = 4;
    localparam int NI     = 5;

    // Instances: 0 XY4, 1 YX4, 2 torus4, 3 mesh5 at x=0, 4 torus5 at x=0
    int cfg_mx   [NI] = '{4, 4, 4, 5, 5};
    int cfg_xc   [NI] = '{2, 2, 2, 0, 0};
    int cfg_mode [NI] = '{0, 1, 0, 0, 0};
    int cfg_tor  [NI] = '{0, 0, 1, 0, 1};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       hv = 1'b0;
    logic       hvc = 1'b0;
    logic [2:0] xd = '0;
    logic [1:0] yd = '0;
    logic       tv = 1'b0;
    logic       tvc = 1'b0;
    logic       started = 1'b0;

    logic [1:0] rv [NI];
    logic [5:0] op [NI];
    logic       er [NI];

    int n_assert = 0;
    int n_fail   = 0;

    bit m_held   [NI][2];
    bit m_single [NI][2];
    int m_port   [NI][2];
    bit m_err    [NI];

    always #5 clk = ~clk;

    rc_unit_vc #(.MESH_SIZE_X(4), .MESH_SIZE_Y(4), .X_CURRENT(2), .Y_CURRENT(2), .VC_NUM(2), .ROUTING_MODE(0), .TORUS(0)) u_xy4 (
        .clk(clk), .rst(rst), .head_valid_i(hv), .head_vc_i(hvc), .x_dest_i(xd[1:0]), .y_dest_i(yd),
        .tail_valid_i(tv), .tail_vc_i(tvc), .route_valid_o(rv[0]), .out_port_o(op[0]), .error_o(er[0]));
    rc_unit_vc #(.MESH_SIZE_X(4), .MESH_SIZE_Y(4), .X_CURRENT(2), .Y_CURRENT(2), .VC_NUM(2), .ROUTING_MODE(1), .TORUS(0)) u_yx4 (
        .clk(clk), .rst(rst), .head_valid_i(hv), .head_vc_i(hvc), .x_dest_i(xd[1:0]), .y_dest_i(yd),
        .tail_valid_i(tv), .tail_vc_i(tvc), .route_valid_o(rv[1]), .out_port_o(op[1]), .error_o(er[1]));
    rc_unit_vc #(.MESH_SIZE_X(4), .MESH_SIZE_Y(4), .X_CURRENT(2), .Y_CURRENT(2), .VC_NUM(2), .ROUTING_MODE(0), .TORUS(1)) u_t4 (
        .clk(clk), .rst(rst), .head_valid_i(hv), .head_vc_i(hvc), .x_dest_i(xd[1:0]), .y_dest_i(yd),
        .tail_valid_i(tv), .tail_vc_i(tvc), .route_valid_o(rv[2]), .out_port_o(op[2]), .error_o(er[2]));
    rc_unit_vc #(.MESH_SIZE_X(5), .MESH_SIZE_Y(4), .X_CURRENT(0), .Y_CURRENT(2), .VC_NUM(2), .ROUTING_MODE(0), .TORUS(0)) u_m5 (
        .clk(clk), .rst(rst), .head_valid_i(hv), .head_vc_i(hvc), .x_dest_i(xd), .y_dest_i(yd),
        .tail_valid_i(tv), .tail_vc_i(tvc), .route_valid_o(rv[3]), .out_port_o(op[3]), .error_o(er[3]));
    rc_unit_vc #(.MESH_SIZE_X(5), .MESH_SIZE_Y(4), .X_CURRENT(0), .Y_CURRENT(2), .VC_NUM(2), .ROUTING_MODE(0), .TORUS(1)) u_t5 (
        .clk(clk), .rst(rst), .head_valid_i(hv), .head_vc_i(hvc), .x_dest_i(xd), .y_dest_i(yd),
        .tail_valid_i(tv), .tail_vc_i(tvc), .route_valid_o(rv[4]), .out_port_o(op[4]), .error_o(er[4]));

    function automatic int axis_dir(int d, int c, int n, int tor, int neg, int pos);
        int off;
        if (tor == 0) return (d < c) ? neg : ((d > c) ? pos : CENTER);
        off = (((d - c) % n) + n) % n;
        if (off == 0) return CENTER;
        return (off <= n / 2) ? pos : neg;
    endfunction

    function automatic int ref_port(int i, int x, int y);
        int ddx, ddy;
        ddx = axis_dir(x, cfg_xc[i], cfg_mx[i], cfg_tor[i], LEFT, RIGHT);
        ddy = axis_dir(y, 2, 4, cfg_tor[i], UP, DOWN);
        if (cfg_mode[i] == 0) return (ddx != CENTER) ? ddx : ddy;
        return (ddy != CENTER) ? ddy : ddx;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NI; i++) begin
                m_err[i] <= 1'b0;
                for (int v = 0; v < 2; v++) begin
                    m_held[i][v]   <= 1'b0;
                    m_single[i][v] <= 1'b0;
                    m_port[i][v]   <= CENTER;
                end
            end
        end else begin
            for (int i = 0; i < NI; i++) begin
                bit e;
                int xi;
                xi = (cfg_mx[i] == 4) ? int'(xd[1:0]) : int'(xd);
                e = 1'b0;
                for (int v = 0; v < 2; v++) begin
                    bit h, t, busy, nh, ns;
                    int np;
                    h = hv && (int'(hvc) == v);
                    t = tv && (int'(tvc) == v);
                    busy = m_held[i][v] && !m_single[i][v];
                    nh = m_single[i][v] ? 1'b0 : m_held[i][v];
                    ns = 1'b0;
                    np = m_port[i][v];
                    if (busy && h && !t) begin
                        e = 1'b1;
                    end else begin
                        if (busy && t) nh = 1'b0;
                        if (!busy && t && !h) e = 1'b1;
                        if (h) begin
                            if (xi < cfg_mx[i] && int'(yd) < 4) begin
                                nh = 1'b1;
                                ns = t && !busy;
                                np = ref_port(i, xi, int'(yd));
                            end else begin
                                e = 1'b1;
                            end
                        end
                    end
                    m_held[i][v]   <= nh;
                    m_single[i][v] <= ns;
                    m_port[i][v]   <= np;
                end
                m_err[i] <= e;
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_assert++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (started) begin
            for (int i = 0; i < NI; i++) begin
                for (int v = 0; v < 2; v++) begin
                    chk($sformatf("model inst%0d vc%0d valid", i, v), int'(rv[i][v]), int'(m_held[i][v]));
                    chk($sformatf("model inst%0d vc%0d port", i, v), int'(op[i][v*3 +: 3]), m_port[i][v]);
                end
                chk($sformatf("model inst%0d error", i), int'(er[i]), int'(m_err[i]));
            end
        end
    end

    task automatic step(input bit h, input bit hc, input int x, input int y, input bit t, input bit tc);
        hv  = h;
        hvc = hc;
        xd  = x[2:0];
        yd  = y[1:0];
        tv  = t;
        tvc = tc;
        @(posedge clk);
        #1;
        hv = 1'b0;
        tv = 1'b0;
    endtask

    initial begin
        #2 rst = 1'b0;
        #1 started = 1'b1;
        @(posedge clk);
        #1;
        chk("reset valid", int'(rv[0]), 0);
        chk("reset ports", int'(op[0]), 0);
        chk("reset error", int'(er[0]), 0);
        @(posedge clk);
        #1 rst = 1'b1;

        for (int x = 0; x < 4; x++) begin
            for (int y = 0; y < 4; y++) begin
                step(1'b1, 1'b0, x, y, 1'b0, 1'b0);
                chk($sformatf("xy valid after head (%0d,%0d)", x, y), int'(rv[0][0]), 1);
                if (x == 0 && y == 3) begin
                    chk("xy (0,3) LEFT", int'(op[0][2:0]), LEFT);
                    chk("yx (0,3) DOWN", int'(op[1][2:0]), DOWN);
                end
                if (x == 3 && y == 0) chk("xy (3,0) RIGHT", int'(op[0][2:0]), RIGHT);
                if (x == 2 && y == 0) begin
                    chk("xy (2,0) UP", int'(op[0][2:0]), UP);
                    chk("torus (2,0) DOWN tie", int'(op[2][2:0]), DOWN);
                end
                if (x == 2 && y == 3) chk("xy (2,3) DOWN", int'(op[0][2:0]), DOWN);
                if (x == 2 && y == 2) chk("xy (2,2) CENTER", int'(op[0][2:0]), CENTER);
                if (x == 2 && y == 1) chk("torus (2,1) UP", int'(op[2][2:0]), UP);
                if (x == 3 && y == 2) begin
                    chk("yx (3,2) RIGHT", int'(op[1][2:0]), RIGHT);
                    chk("torus x=3 RIGHT", int'(op[2][2:0]), RIGHT);
                end
                if (x == 1 && y == 1) chk("yx (1,1) UP", int'(op[1][2:0]), UP);
                if (x == 0 && y == 2) chk("torus x=0 RIGHT tie", int'(op[2][2:0]), RIGHT);
                if (x == 1 && y == 2) chk("torus x=1 LEFT", int'(op[2][2:0]), LEFT);
                step(1'b0, 1'b0, 0, 0, 1'b1, 1'b0);
                chk($sformatf("xy valid after tail (%0d,%0d)", x, y), int'(rv[0][0]), 0);
            end
        end

        step(1'b1, 1'b0, 4, 2, 1'b0, 1'b0);
        chk("torus5 (4,2) LEFT", int'(op[4][2:0]), LEFT);
        chk("mesh5 (4,2) RIGHT", int'(op[3][2:0]), RIGHT);
        step(1'b0, 1'b0, 0, 0, 1'b1, 1'b0);

        step(1'b1, 1'b1, 3, 2, 1'b1, 1'b1);
        chk("single flit valid", int'(rv[0][1]), 1);
        step(1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
        chk("single flit released", int'(rv[0][1]), 0);

        step(1'b1, 1'b1, 3, 2, 1'b0, 1'b0);
        chk("vc1 routed RIGHT", int'(op[0][5:3]), RIGHT);
        step(1'b1, 1'b1, 0, 2, 1'b1, 1'b1);
        chk("back-to-back valid", int'(rv[0][1]), 1);
        chk("back-to-back port LEFT", int'(op[0][5:3]), LEFT);
        chk("back-to-back no error", int'(er[0]), 0);

        step(1'b1, 1'b0, 3, 2, 1'b1, 1'b1);
        chk("independent vcs", int'(rv[0]), 1);

        step(1'b1, 1'b0, 0, 2, 1'b0, 1'b0);
        chk("head on routed error", int'(er[0]), 1);
        chk("head on routed port kept", int'(op[0][2:0]), RIGHT);
        chk("head on routed valid kept", int'(rv[0][0]), 1);
        step(1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
        chk("error is one cycle", int'(er[0]), 0);
        step(1'b0, 1'b0, 0, 0, 1'b1, 1'b0);

        step(1'b1, 1'b0, 5, 2, 1'b0, 1'b0);
        chk("range error mesh5", int'(er[3]), 1);
        chk("range vc stays idle", int'(rv[3][0]), 0);
        chk("range error torus5", int'(er[4]), 1);
        step(1'b0, 1'b0, 0, 0, 1'b1, 1'b0);

        step(1'b0, 1'b0, 0, 0, 1'b1, 1'b1);
        chk("tail on idle error", int'(er[0]), 1);

        step(1'b1, 1'b0, 3, 2, 1'b0, 1'b0);
        step(1'b1, 1'b1, 0, 2, 1'b0, 1'b0);
        chk("two vcs routed", int'(rv[0]), 3);
        #2 rst = 1'b0;
        #1;
        chk("async reset valid", int'(rv[0]), 0);
        chk("async reset ports CENTER", int'(op[0]), 0);
        chk("async reset torus valid", int'(rv[2]), 0);
        @(posedge clk);
        #1 rst = 1'b1;
        step(1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 0, 0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
